// File: rtl/dac_ctrl_seq.sv
// Power sequencer and segmented code driver for the DAC output stage.
// Brings the driver cells up, streams saturated codes into them, and parks them at zero code before power-down.
module dac_ctrl_seq #(
  parameter int PWRUP_CYCLES = 16,
  parameter int PDN_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        supply_ok,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic [11:0] code,
  output logic [6:0]  datain,
  output logic [6:0]  datainb,
  output logic [16:0] datatherm,
  output logic [16:0] datathermb,
  output logic        pdb,
  output logic        fault,
  output logic        sat,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    WAIT_SUP = 3'd1,
    PWRUP    = 3'd2,
    ACTIVE   = 3'd3,
    PDN_PARK = 3'd4,
    PDN_OFF  = 3'd5
  } state_t;

  localparam logic [11:0] CODE_MAX = 12'd2303;
  localparam logic [7:0]  PWRUP_LD = 8'(PWRUP_CYCLES - 1);
  localparam logic [7:0]  PDN_LD   = 8'(PDN_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        pdb_q;
  logic        fault_q;
  logic        sat_q;
  logic [6:0]  din_q;
  logic [16:0] therm_q;
  logic [11:0] code_clip;

  function automatic logic [11:0] clip_code(input logic [11:0] c);
    return (c > CODE_MAX) ? CODE_MAX : c;
  endfunction

  // Thermometer decode of the MSB segment: the lowest m cells are on.
  function automatic logic [16:0] therm_dec(input logic [4:0] m);
    logic [16:0] t;
    for (int i = 0; i < 17; i++) t[i] = (5'(i) < m);
    return t;
  endfunction

  assign code_clip  = clip_code(code);
  assign code_ready = (state_q == ACTIVE) && en && supply_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= 8'd0;
      pdb_q   <= 1'b0;
      fault_q <= 1'b0;
      sat_q   <= 1'b0;
      din_q   <= 7'd0;
      therm_q <= 17'd0;
    end else begin
      sat_q <= 1'b0;
      case (state_q)
        OFF: begin
          if (!en) fault_q <= 1'b0;
          else if (!fault_q) state_q <= WAIT_SUP;
        end
        WAIT_SUP: begin
          if (!en) begin
            state_q <= OFF;
          end else if (supply_ok) begin
            state_q <= PWRUP;
            cnt_q   <= PWRUP_LD;
            pdb_q   <= 1'b1;
          end
        end
        PWRUP, ACTIVE: begin
          // A supply loss wins over a simultaneous enable drop so it is always latched as a fault.
          if (!supply_ok) begin
            fault_q <= 1'b1;
            state_q <= PDN_PARK;
          end else if (!en) begin
            state_q <= PDN_PARK;
          end else if (state_q == PWRUP) begin
            if (cnt_q == 8'd0) state_q <= ACTIVE;
            else cnt_q <= cnt_q - 8'd1;
          end else if (code_valid) begin
            din_q   <= code_clip[6:0];
            therm_q <= therm_dec(code_clip[11:7]);
            sat_q   <= (code > CODE_MAX);
          end
        end
        PDN_PARK: begin
          din_q   <= 7'd0;
          therm_q <= 17'd0;
          cnt_q   <= PDN_LD;
          state_q <= PDN_OFF;
        end
        PDN_OFF: begin
          if (cnt_q == 8'd0) begin
            state_q <= OFF;
            pdb_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= OFF;
      endcase
    end
  end

  assign datain     = din_q;
  assign datainb    = ~din_q;
  assign datatherm  = therm_q;
  assign datathermb = ~therm_q;
  assign pdb        = pdb_q;
  assign fault      = fault_q;
  assign sat        = sat_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_dac_ctrl_seq.sv
// Scoreboard bench for dac_ctrl_seq: stimulus pushes time-tagged expected outputs,
// a negedge monitor pops and compares them and checks that outputs hold between updates.
module tb_dac_ctrl_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        supply_ok = 1'b0;
  logic        code_valid = 1'b0;
  logic [11:0] code = 12'd0;
  logic        code_ready;
  logic [6:0]  datain, datainb;
  logic [16:0] datatherm, datathermb;
  logic        pdb, fault, sat;
  logic [2:0]  state_o;

  dac_ctrl_seq #(.PWRUP_CYCLES(16), .PDN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .supply_ok(supply_ok),
    .code_valid(code_valid), .code_ready(code_ready), .code(code),
    .datain(datain), .datainb(datainb), .datatherm(datatherm), .datathermb(datathermb),
    .pdb(pdb), .fault(fault), .sat(sat), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int          tag;
    logic [6:0]  din;
    logic [16:0] th;
    logic        s;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: clip to 2303, low 7 bits drive the binary cells, the rest count thermometer cells.
  function automatic exp_t model(input int tag, input logic [11:0] c_in);
    exp_t e;
    int c, m;
    c = (c_in > 12'd2303) ? 2303 : int'(c_in);
    m = c / 128;
    e.tag = tag;
    e.din = 7'(c % 128);
    e.th  = 17'((1 << m) - 1);
    e.s   = (c_in > 12'd2303);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_zero(input int dly);
    exp_t e;
    e.tag = cyc + dly; e.din = 7'd0; e.th = 17'd0; e.s = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drive_code(input logic [11:0] c);
    code_valid = 1'b1;
    code = c;
    sb.push_back(model(cyc + 1, c));
    step();
  endtask

  task automatic power_up();
    en = 1'b1; supply_ok = 1'b1;
    code_valid = 1'b1; code = 12'($urandom);
    step();
    chk("pu_wait_state", 32'(state_o), 32'd1);
    chk("pu_wait_pdb", 32'(pdb), 32'd0);
    step();
    chk("pu_pwrup_state", 32'(state_o), 32'd2);
    chk("pu_pwrup_pdb", 32'(pdb), 32'd1);
    chk("pu_pwrup_ready", 32'(code_ready), 32'd0);
    repeat (15) step();
    chk("pu_last_pwrup_ready", 32'(code_ready), 32'd0);
    step();
    chk("pu_active_state", 32'(state_o), 32'd3);
    chk("pu_active_ready", 32'(code_ready), 32'd1);
    code_valid = 1'b0;
  endtask

  logic [6:0]  m_din = 7'd0;
  logic [16:0] m_th = 17'd0;
  logic        m_sat;
  logic [6:0]  m_dinb;
  logic [16:0] m_thb;

  always @(negedge clk) begin
    if (mon_on) begin
      m_sat = 1'b0;
      while (sb.size() > 0 && sb[0].tag < cyc) begin
        chk("sb_stale_entry", 32'(sb[0].tag), 32'(cyc));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].tag == cyc) begin
        m_din = sb[0].din;
        m_th  = sb[0].th;
        m_sat = sb[0].s;
        void'(sb.pop_front());
      end
      m_dinb = ~m_din;
      m_thb  = ~m_th;
      chk("datain", 32'(datain), 32'(m_din));
      chk("datainb", 32'(datainb), 32'(m_dinb));
      chk("datatherm", 32'(datatherm), 32'(m_th));
      chk("datathermb", 32'(datathermb), 32'(m_thb));
      chk("sat", 32'(sat), 32'(m_sat));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v;
    logic [11:0] c;

    step(); step();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pdb", 32'(pdb), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_ready", 32'(code_ready), 32'd0);
    chk("rst_datain", 32'(datain), 32'd0);
    chk("rst_datathermb", 32'(datathermb), 32'h1FFFF);
    rst = 1'b0;
    mon_on = 1'b1;
    step(); step();

    power_up();
    drive_code(12'd300);
    drive_code(12'd4095);
    drive_code(12'd2303);
    drive_code(12'd0);
    drive_code(12'd127);
    drive_code(12'd128);
    code_valid = 1'b0;
    step(); step();

    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(2304, 4095)) : 12'($urandom_range(0, 2303));
      code = c;
      code_valid = v;
      if (v) sb.push_back(model(cyc + 1, c));
      step();
    end
    code_valid = 1'b0;
    step();

    // Enable drop with a pending valid: no transfer, park, then power down.
    code_valid = 1'b1; code = 12'd1000; en = 1'b0;
    push_zero(2);
    step();
    chk("dis_park_state", 32'(state_o), 32'd4);
    chk("dis_park_ready", 32'(code_ready), 32'd0);
    chk("dis_park_pdb", 32'(pdb), 32'd1);
    code_valid = 1'b0;
    step();
    chk("dis_pdnoff_state", 32'(state_o), 32'd5);
    repeat (3) step();
    chk("dis_pdnoff_pdb", 32'(pdb), 32'd1);
    step();
    chk("dis_off_state", 32'(state_o), 32'd0);
    chk("dis_off_pdb", 32'(pdb), 32'd0);
    chk("dis_off_fault", 32'(fault), 32'd0);
    step();

    // Supply loss in ACTIVE latches a fault that blocks restart until en drops.
    power_up();
    drive_code(12'd3000);
    drive_code(12'd1500);
    code_valid = 1'b0;
    supply_ok = 1'b0;
    push_zero(2);
    step();
    chk("sup_fault", 32'(fault), 32'd1);
    chk("sup_park_state", 32'(state_o), 32'd4);
    step();
    repeat (4) step();
    chk("sup_off_state", 32'(state_o), 32'd0);
    chk("sup_off_pdb", 32'(pdb), 32'd0);
    supply_ok = 1'b1;
    repeat (5) step();
    chk("sup_held_state", 32'(state_o), 32'd0);
    chk("sup_held_fault", 32'(fault), 32'd1);
    en = 1'b0;
    step();
    chk("sup_clear_fault", 32'(fault), 32'd0);
    chk("sup_clear_state", 32'(state_o), 32'd0);

    // en and supply_ok falling together take the fault path.
    power_up();
    drive_code(12'd777);
    code_valid = 1'b0;
    en = 1'b0; supply_ok = 1'b0;
    push_zero(2);
    step();
    chk("both_fault", 32'(fault), 32'd1);
    chk("both_state", 32'(state_o), 32'd4);
    repeat (5) step();
    chk("both_off_state", 32'(state_o), 32'd0);
    chk("both_off_fault", 32'(fault), 32'd1);
    step();
    chk("both_clear_fault", 32'(fault), 32'd0);

    // Reset while the power-up counter reads 5.
    en = 1'b1; supply_ok = 1'b1;
    step(); step();
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("rstpu_state", 32'(state_o), 32'd0);
    chk("rstpu_pdb", 32'(pdb), 32'd0);
    chk("rstpu_ready", 32'(code_ready), 32'd0);
    rst = 1'b0;

    // Reset in ACTIVE with non-zero outputs returns them to zero code immediately.
    power_up();
    drive_code(12'd2200);
    code_valid = 1'b0;
    rst = 1'b1;
    push_zero(1);
    step();
    chk("rstact_state", 32'(state_o), 32'd0);
    chk("rstact_pdb", 32'(pdb), 32'd0);
    chk("rstact_fault", 32'(fault), 32'd0);
    rst = 1'b0; en = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
